// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared types, saturation limits and clamp helper for the pe_mx processing element
package pe_pkg;

  typedef enum logic [1:0] {
    GEMM_WS = 2'b00,
    GEMM_OS = 2'b01,
    UNO     = 2'b10,
    BYPASS  = 2'b11
  } pe_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACC   = 2'b01,
    DRAIN = 2'b10
  } os_state_e;

  localparam int SAT_CALC_BW = 64;

  function automatic logic signed [SAT_CALC_BW-1:0] sat_max(input int bw);
    return (64'sd1 <<< (bw - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [SAT_CALC_BW-1:0] sat_min(input int bw);
    return -(64'sd1 <<< (bw - 1));
  endfunction

  // Clamp a wide signed value into a bw-bit signed range; callers truncate the result to bw.
  function automatic logic signed [SAT_CALC_BW-1:0] sat(input logic signed [SAT_CALC_BW-1:0] v,
                                                        input int bw);
    if (v > sat_max(bw)) begin
      return sat_max(bw);
    end else if (v < sat_min(bw)) begin
      return sat_min(bw);
    end
    return v;
  endfunction

endpackage

// File: rtl/pe_mul_sat.sv
// rtl/pe_mul_sat.sv - signed multiplier, optional product register and saturating adder
module pe_mul_sat
  import pe_pkg::*;
#(
  parameter int OP_BW    = 16,
  parameter int ACC_BW   = 32,
  parameter int MUL_PIPE = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [OP_BW-1:0]  a_i,
  input  logic signed [OP_BW-1:0]  b_i,
  input  logic                     vld_i,
  input  logic signed [ACC_BW-1:0] addend_i,
  output logic signed [ACC_BW-1:0] prod_o,
  output logic                     vld_o,
  output logic signed [ACC_BW-1:0] sum_o
);

  logic signed [2*OP_BW-1:0] prod_full;
  logic signed [ACC_BW-1:0]  prod_d, prod_q;
  logic                      pvld_d, pvld_q;
  logic signed [63:0]        sum_w;

  assign prod_full = a_i * b_i;

  always_comb begin
    prod_d = ACC_BW'(prod_full);
    pvld_d = vld_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      pvld_q <= 1'b0;
    end else begin
      prod_q <= prod_d;
      pvld_q <= pvld_d;
    end
  end

  // With MUL_PIPE=0 the register is simply left unused and optimised away.
  assign prod_o = (MUL_PIPE != 0) ? prod_q : prod_d;
  assign vld_o  = (MUL_PIPE != 0) ? pvld_q : pvld_d;

  assign sum_w = 64'(prod_o) + 64'(addend_i);
  assign sum_o = ACC_BW'(sat(sum_w, ACC_BW));

endmodule

// File: rtl/pe_mx.sv
// rtl/pe_mx.sv - systolic processing element: WS/OS GEMM, unary chain and bypass modes
module pe_mx
  import pe_pkg::*;
#(
  parameter int INT_BW   = 5,
  parameter int FRA_BW   = 10,
  parameter int MUL_BW   = 16,
  parameter int ACC_BW   = 32,
  parameter int MUL_PIPE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode_i,
  input  logic [MUL_BW-1:0] x_i,
  input  logic              x_vld_i,
  input  logic [MUL_BW-1:0] var_i,
  input  logic [MUL_BW-1:0] wc_i,
  input  logic              w_shift_i,
  input  logic              w_load_i,
  input  logic [ACC_BW-1:0] mac_i,
  input  logic [ACC_BW-1:0] o_i,
  input  logic              o_vld_i,
  input  logic              acc_start_i,
  input  logic              drain_i,
  output logic [MUL_BW-1:0] x_o,
  output logic              x_vld_o,
  output logic [MUL_BW-1:0] var_o,
  output logic [MUL_BW-1:0] wc_o,
  output logic [ACC_BW-1:0] o_o,
  output logic              o_vld_o,
  output logic              busy_o
);

  localparam int OP_BW = 1 + INT_BW + FRA_BW;

  pe_mode_e mode;
  assign mode = pe_mode_e'(mode_i);

  logic [MUL_BW-1:0] x_d, x_q, var_d, var_q, shadow_d, shadow_q, active_d, active_q;
  logic              x_vld_d, x_vld_q;
  logic [ACC_BW-1:0] o_d, o_q, acc_d, acc_q;
  logic              o_vld_d, o_vld_q;
  os_state_e         state_d, state_q;

  always_comb begin
    x_d      = x_i;
    x_vld_d  = x_vld_i;
    var_d    = var_i;
    shadow_d = w_shift_i ? wc_i : shadow_q;
    // Reading shadow_q here means a simultaneous shift+load promotes the old shadow.
    active_d = w_load_i ? shadow_q : active_q;
  end

  logic signed [OP_BW-1:0]  x_op, var_op, w_op, mac_t;
  logic signed [ACC_BW-1:0] mac_shift, w_ext, addend;
  logic signed [OP_BW-1:0]  mul_a, mul_b;
  logic                     mul_vld;
  logic signed [ACC_BW-1:0] prod, sum;
  logic                     pvld;

  assign x_op      = $signed(x_q[MUL_BW-1 -: OP_BW]);
  assign var_op    = $signed(var_q[MUL_BW-1 -: OP_BW]);
  assign w_op      = $signed(active_q[MUL_BW-1 -: OP_BW]);
  assign mac_shift = $signed(mac_i) >>> FRA_BW;
  assign mac_t     = OP_BW'(sat(64'(mac_shift), OP_BW));
  assign w_ext     = ACC_BW'(w_op) <<< FRA_BW;

  always_comb begin
    mul_a   = w_op;
    mul_b   = x_op;
    mul_vld = x_vld_q;
    addend  = $signed(o_i);
    case (mode)
      GEMM_OS: addend = $signed(acc_q);
      UNO: begin
        mul_a   = mac_t;
        mul_b   = var_op;
        mul_vld = 1'b1;
        addend  = w_ext;
      end
      default: ;
    endcase
  end

  pe_mul_sat #(
    .OP_BW   (OP_BW),
    .ACC_BW  (ACC_BW),
    .MUL_PIPE(MUL_PIPE)
  ) u_mul_sat (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_i     (mul_a),
    .b_i     (mul_b),
    .vld_i   (mul_vld),
    .addend_i(addend),
    .prod_o  (prod),
    .vld_o   (pvld),
    .sum_o   (sum)
  );

  always_comb begin
    o_d     = o_q;
    o_vld_d = o_vld_q;
    acc_d   = acc_q;
    state_d = state_q;
    case (mode)
      GEMM_WS: begin
        o_d     = sum;
        o_vld_d = pvld;
      end
      UNO: begin
        o_d     = sum;
        o_vld_d = 1'b1;
      end
      BYPASS: begin
        o_d     = o_i;
        o_vld_d = o_vld_i;
      end
      GEMM_OS: begin
        case (state_q)
          ACC: begin
            o_vld_d = 1'b0;
            if (!acc_start_i) begin
              if (pvld) begin
                acc_d = sum;
              end
              // The drained value includes a product landing on this same edge.
              if (drain_i) begin
                state_d = DRAIN;
                o_d     = acc_d;
                o_vld_d = 1'b1;
              end
            end
          end
          DRAIN: begin
            o_d     = o_i;
            o_vld_d = o_vld_i;
            if (!drain_i) begin
              state_d = IDLE;
            end
          end
          default: begin
            o_d     = o_i;
            o_vld_d = o_vld_i;
          end
        endcase
        if (acc_start_i) begin
          state_d = ACC;
          acc_d   = pvld ? prod : '0;
        end
      end
      default: ;
    endcase
    if (mode != GEMM_OS) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q      <= '0;
      x_vld_q  <= 1'b0;
      var_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      o_q      <= '0;
      o_vld_q  <= 1'b0;
      acc_q    <= '0;
      state_q  <= IDLE;
    end else begin
      x_q      <= x_d;
      x_vld_q  <= x_vld_d;
      var_q    <= var_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      o_q      <= o_d;
      o_vld_q  <= o_vld_d;
      acc_q    <= acc_d;
      state_q  <= state_d;
    end
  end

  assign x_o     = x_q;
  assign x_vld_o = x_vld_q;
  assign var_o   = var_q;
  assign wc_o    = shadow_q;
  assign o_o     = o_q;
  assign o_vld_o = o_vld_q;
  assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_pe_mx.sv
// tb/tb_pe_mx.sv - directed table-driven bench for pe_mx (MUL_PIPE=0 and MUL_PIPE=1 instances)
module tb_pe_mx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode_i;
  logic [15:0] x_i, var_i, wc_i;
  logic        x_vld_i, w_shift_i, w_load_i, o_vld_i, acc_start_i, drain_i;
  logic [31:0] mac_i, o_i;

  logic [15:0] x_o, var_o, wc_o, p_x_o, p_var_o, p_wc_o;
  logic        x_vld_o, o_vld_o, busy_o, p_x_vld_o, p_o_vld_o, p_busy_o;
  logic [31:0] o_o, p_o_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  pe_mx #(.MUL_PIPE(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .mode_i(mode_i), .x_i(x_i), .x_vld_i(x_vld_i),
    .var_i(var_i), .wc_i(wc_i), .w_shift_i(w_shift_i), .w_load_i(w_load_i),
    .mac_i(mac_i), .o_i(o_i), .o_vld_i(o_vld_i), .acc_start_i(acc_start_i),
    .drain_i(drain_i), .x_o(x_o), .x_vld_o(x_vld_o), .var_o(var_o), .wc_o(wc_o),
    .o_o(o_o), .o_vld_o(o_vld_o), .busy_o(busy_o)
  );

  pe_mx #(.MUL_PIPE(1)) u_dut_p (
    .clk(clk), .rst_n(rst_n), .mode_i(mode_i), .x_i(x_i), .x_vld_i(x_vld_i),
    .var_i(var_i), .wc_i(wc_i), .w_shift_i(w_shift_i), .w_load_i(w_load_i),
    .mac_i(mac_i), .o_i(o_i), .o_vld_i(o_vld_i), .acc_start_i(acc_start_i),
    .drain_i(drain_i), .x_o(p_x_o), .x_vld_o(p_x_vld_o), .var_o(p_var_o), .wc_o(p_wc_o),
    .o_o(p_o_o), .o_vld_o(p_o_vld_o), .busy_o(p_busy_o)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] w;
    logic [15:0] x;
    logic        xv;
    logic [15:0] vr;
    logic [31:0] mac;
    logic [31:0] oi;
    logic        ovi;
    logic [31:0] exp_o;
    logic        exp_v;
  } vec_t;

  vec_t vecs[9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic load_w(input logic [15:0] w);
    wc_i      = w;
    w_shift_i = 1'b1;
    step();
    w_shift_i = 1'b0;
    w_load_i  = 1'b1;
    step();
    w_load_i  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //              mode   w         x         xv    var       mac            o_i            ovi   exp_o          exp_v
    vecs[0] = '{2'b00, 16'h0400, 16'h0800, 1'b1, 16'h0000, 32'h0000_0000, 32'h0010_0000, 1'b0, 32'h0030_0000, 1'b1};
    vecs[1] = '{2'b00, 16'h7FFF, 16'h7FFF, 1'b1, 16'h0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1};
    vecs[2] = '{2'b00, 16'h8000, 16'h7FFF, 1'b1, 16'h0000, 32'h0000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b1};
    vecs[3] = '{2'b00, 16'hFC00, 16'h0800, 1'b1, 16'h0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'hFFE0_0000, 1'b1};
    vecs[4] = '{2'b00, 16'h0400, 16'h0400, 1'b0, 16'h0000, 32'h0000_0000, 32'h0000_0005, 1'b0, 32'h0010_0005, 1'b0};
    vecs[5] = '{2'b10, 16'h0000, 16'h0000, 1'b0, 16'h0400, 32'h7FFF_FFFF, 32'h0000_0000, 1'b0, 32'h01FF_FC00, 1'b1};
    vecs[6] = '{2'b10, 16'h0000, 16'h0000, 1'b0, 16'h0400, 32'h8000_0000, 32'h0000_0000, 1'b0, 32'hFE00_0000, 1'b1};
    vecs[7] = '{2'b10, 16'h0400, 16'h0000, 1'b0, 16'h0C00, 32'h0000_0800, 32'h0000_0000, 1'b0, 32'h0010_1800, 1'b1};
    vecs[8] = '{2'b11, 16'h0000, 16'h1234, 1'b0, 16'h0000, 32'h0000_0000, 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1};

    rst_n = 1'b0; mode_i = 2'b00; x_i = '0; var_i = '0; wc_i = '0;
    x_vld_i = 0; w_shift_i = 0; w_load_i = 0; o_vld_i = 0; acc_start_i = 0; drain_i = 0;
    mac_i = '0; o_i = '0;
    step(); step();
    rst_n = 1'b1;
    chk("rst_o", o_o, 32'h0);
    chk("rst_o_vld", {31'b0, o_vld_o}, 32'h0);
    chk("rst_x_o", {16'b0, x_o}, 32'h0);
    chk("rst_wc_o", {16'b0, wc_o}, 32'h0);
    chk("rst_busy", {31'b0, busy_o}, 32'h0);
    chk("rst_p_o", p_o_o, 32'h0);

    for (int i = 0; i < 9; i++) begin
      load_w(vecs[i].w);
      mode_i = vecs[i].mode; x_i = vecs[i].x; x_vld_i = vecs[i].xv; var_i = vecs[i].vr;
      mac_i = vecs[i].mac; o_i = vecs[i].oi; o_vld_i = vecs[i].ovi;
      step();
      chk($sformatf("vec%0d_x_o", i), {16'b0, x_o}, {16'b0, vecs[i].x});
      chk($sformatf("vec%0d_var_o", i), {16'b0, var_o}, {16'b0, vecs[i].vr});
      x_vld_i = 1'b0;
      step();
      chk($sformatf("vec%0d_o", i), o_o, vecs[i].exp_o);
      chk($sformatf("vec%0d_vld", i), {31'b0, o_vld_o}, {31'b0, vecs[i].exp_v});
    end

    // latency: 2 cycles without the product register, 3 with it
    mode_i = 2'b00; o_vld_i = 0; x_i = '0; x_vld_i = 0; mac_i = '0; var_i = '0;
    load_w(16'h0400);
    o_i = 32'h0010_0000;
    step();
    x_i = 16'h0800; x_vld_i = 1'b1;
    step();
    x_i = '0; x_vld_i = 1'b0;
    chk("lat_e1_vld", {31'b0, o_vld_o}, 32'h0);
    step();
    chk("lat_e2_o", o_o, 32'h0030_0000);
    chk("lat_e2_vld", {31'b0, o_vld_o}, 32'h1);
    chk("lat_e2_p_vld", {31'b0, p_o_vld_o}, 32'h0);
    step();
    chk("lat_e3_p_o", p_o_o, 32'h0030_0000);
    chk("lat_e3_p_vld", {31'b0, p_o_vld_o}, 32'h1);
    chk("lat_e3_vld", {31'b0, o_vld_o}, 32'h0);

    // output-stationary accumulate and drain
    mode_i = 2'b01; o_i = '0; o_vld_i = 0; acc_start_i = 1'b1;
    step();
    acc_start_i = 1'b0;
    chk("os_busy_acc", {31'b0, busy_o}, 32'h1);
    x_i = 16'h0400; x_vld_i = 1'b1;
    repeat (4) step();
    x_vld_i = 1'b0;
    step();
    chk("os_acc_vld", {31'b0, o_vld_o}, 32'h0);
    o_i = 32'h55; o_vld_i = 1'b1; drain_i = 1'b1;
    step();
    chk("os_drain_o", o_o, 32'h0040_0000);
    chk("os_drain_vld", {31'b0, o_vld_o}, 32'h1);
    step();
    chk("os_fwd1_o", o_o, 32'h55);
    chk("os_fwd1_vld", {31'b0, o_vld_o}, 32'h1);
    step();
    chk("os_fwd2_o", o_o, 32'h55);
    chk("os_busy_drain", {31'b0, busy_o}, 32'h1);
    drain_i = 1'b0;
    step();
    chk("os_idle_busy", {31'b0, busy_o}, 32'h0);

    // weight double buffer
    mode_i = 2'b00; o_i = '0; o_vld_i = 0; x_vld_i = 0;
    wc_i = 16'h0C00; w_shift_i = 1'b1;
    step();
    wc_i = 16'h0200; w_load_i = 1'b1;
    step();
    w_shift_i = 1'b0; w_load_i = 1'b0;
    chk("dbuf_wc_o", {16'b0, wc_o}, 32'h0200);
    x_i = 16'h0400; x_vld_i = 1'b1;
    step(); step();
    chk("dbuf_active_a", o_o, 32'h0030_0000);
    w_load_i = 1'b1;
    step();
    w_load_i = 1'b0;
    step();
    chk("dbuf_active_b", o_o, 32'h0008_0000);
    x_vld_i = 1'b0;

    // asynchronous reset during accumulation
    mode_i = 2'b01; o_i = 32'h55; o_vld_i = 1'b1;
    step();
    acc_start_i = 1'b1;
    step();
    acc_start_i = 1'b0; x_i = 16'h0400; x_vld_i = 1'b1;
    step(); step();
    chk("rstacc_pre_busy", {31'b0, busy_o}, 32'h1);
    chk("rstacc_pre_o", o_o, 32'h55);
    rst_n = 1'b0;
    #1;
    chk("rstacc_o", o_o, 32'h0);
    chk("rstacc_vld", {31'b0, o_vld_o}, 32'h0);
    chk("rstacc_x_o", {16'b0, x_o}, 32'h0);
    chk("rstacc_wc_o", {16'b0, wc_o}, 32'h0);
    chk("rstacc_busy", {31'b0, busy_o}, 32'h0);
    #2;
    rst_n = 1'b1;
    x_vld_i = 1'b0; o_i = '0; o_vld_i = 1'b1; drain_i = 1'b1;
    step();
    chk("post_rst_drain_o", o_o, 32'h0);
    chk("post_rst_busy", {31'b0, busy_o}, 32'h0);
    drain_i = 1'b0;
    step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
